multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port op  input  6  opcode field of instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory completes current access this cycle.
REQ-007 SHALL have port pcen  output  1  PC register enable.
REQ-008 SHALL have port irwrite  output  1  instruction register load.
REQ-009 SHALL have port iord  output  1  memory address select, 0=PC, 1=ALUOut.
REQ-010 SHALL have port memwrite  output  1  memory write strobe.
REQ-011 SHALL have port regwrite  output  1  register file write.
REQ-012 SHALL have port regdst  output  1  destination select, 1=rd, 0=rt.
REQ-013 SHALL have port memtoreg  output  1  writeback select, 1=Data, 0=ALUOut.
REQ-014 SHALL have port alusrca  output  1  ALU A select, 0=PC, 1=A reg.
REQ-015 SHALL have port alusrcb  output  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2.
REQ-016 SHALL have port aluop  output  2  00=add, 01=sub, 10=funct-decoded.
REQ-017 SHALL have port pcsrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target.
REQ-018 SHALL have port illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-019 SHALL have port state  output  4  current state encoding, debug only.

Function
REQ-020 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, SUBIEX, IMMWB, JUMP; outputs not listed for a state SHALL be 0.
REQ-021 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite and internal pcwrite = mem_ready; stays in FETCH while mem_ready=0, else -> DECODE.
REQ-022 DECODE: alusrca=0, alusrcb=11, aluop=00; next by op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEX, 000011->SUBIEX, 000010->JUMP, 000001 (nop)->FETCH, other->FETCH with illegal=1 this cycle.
REQ-023 MEMADR: alusrca=1, alusrcb=10, aluop=00; -> MEMRD if op=100011, else MEMWR.
REQ-024 MEMRD: iord=1; holds until mem_ready=1, then -> MEMWB.
REQ-025 MEMWR: iord=1, memwrite=1 held every cycle until mem_ready=1, then -> FETCH.
REQ-026 MEMWB: regdst=0, memtoreg=1, regwrite=1; -> FETCH.
REQ-027 EXECUTE: alusrca=1, alusrcb=00, aluop=10; -> ALUWB. ALUWB: regdst=1, memtoreg=0, regwrite=1; -> FETCH.
REQ-028 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, internal branch=1; -> FETCH.
REQ-029 ADDIEX: alusrca=1, alusrcb=10, aluop=00; SUBIEX same with aluop=01; both -> IMMWB. IMMWB: regdst=0, memtoreg=0, regwrite=1; -> FETCH.
REQ-030 JUMP: pcsrc=10, internal pcwrite=1; -> FETCH.
REQ-031 pcen SHALL equal pcwrite OR (branch AND zero), combinational.
REQ-032 With mem_ready tied 1, cycles per instruction SHALL be: LW 5, SW 4, R-type 4, ADDI 4, SUBI 4, BEQ 3, J 3, nop 2, illegal 2; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR SHALL add exactly one cycle.
REQ-033 regwrite, memwrite, irwrite, pcen SHALL never assert in the same cycle as illegal.

Reset
REQ-034 reset_n=0 SHALL force state to FETCH immediately, independent of clk, and hold all outputs at 0 (irwrite, pcen, illegal included) except alusrcb=01.
REQ-035 Reset asserted mid-instruction (including a stalled MEMWR) SHALL abort it with no further write strobe; first FETCH after release SHALL behave as REQ-021.

Structure
REQ-036 State enum (4-bit) and opcode constants SHALL live in shared package mips_ctrl_pkg, also used by maindec.
REQ-037 Next-state logic SHALL be a single always_comb; state register a single always_ff with async active-low reset.
REQ-038 Output decode SHALL be sub-module ctrl_outdec (state, mem_ready -> control outputs).

Verification
REQ-039 op=100011, mem_ready=1, after reset -> states F,D,MA,MR,MWB; regwrite=1, memtoreg=1 only in cycle 5.
REQ-040 op=101011, mem_ready=0 for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, iord=1, then FETCH.
REQ-041 op=000100, zero=1 -> pcen=1 in BRANCH with pcsrc=01; zero=0 -> pcen=0; 3 cycles each.
REQ-042 op=000011 -> SUBIEX aluop=01, alusrcb=10, then IMMWB regwrite=1, regdst=0.
REQ-043 op=111111 -> illegal=1 one cycle in DECODE, no write strobes, next state FETCH.
REQ-044 reset_n low mid-MEMWR stall -> memwrite drops immediately, state=FETCH, pcen=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared state encodings, opcodes and control-field constants for
//            the multicycle MIPS controller and its main decoder.
// Revision : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam logic [3:0] c_FETCH   = 4'd0;
    localparam logic [3:0] c_DECODE  = 4'd1;
    localparam logic [3:0] c_MEMADR  = 4'd2;
    localparam logic [3:0] c_MEMRD   = 4'd3;
    localparam logic [3:0] c_MEMWB   = 4'd4;
    localparam logic [3:0] c_MEMWR   = 4'd5;
    localparam logic [3:0] c_EXECUTE = 4'd6;
    localparam logic [3:0] c_ALUWB   = 4'd7;
    localparam logic [3:0] c_BRANCH  = 4'd8;
    localparam logic [3:0] c_ADDIEX  = 4'd9;
    localparam logic [3:0] c_SUBIEX  = 4'd10;
    localparam logic [3:0] c_IMMWB   = 4'd11;
    localparam logic [3:0] c_JUMP    = 4'd12;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_SUBI  = 6'b000011;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_NOP   = 6'b000001;

    localparam logic [1:0] c_SRCB_B     = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       irwrite;
        logic       iord;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctrl_t;

    function automatic logic is_supported_op(input logic [5:0] opcode);
        case (opcode)
            c_OP_LW, c_OP_SW, c_OP_RTYPE, c_OP_BEQ,
            c_OP_ADDI, c_OP_SUBI, c_OP_J, c_OP_NOP: is_supported_op = 1'b1;
            default:                                is_supported_op = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_outdec.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_outdec
// Purpose  : Moore output decode: state (plus memory handshake) to controls.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       irwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        case (state)
            c_FETCH: begin
                // PC and IR only advance once the instruction word is back
                w_ctrl.irwrite = mem_ready;
                w_ctrl.pcwrite = mem_ready;
                w_ctrl.alusrcb = c_SRCB_FOUR;
                w_ctrl.aluop   = c_ALUOP_ADD;
                w_ctrl.pcsrc   = c_PCSRC_ALU;
            end
            c_DECODE: begin
                w_ctrl.alusrcb = c_SRCB_IMMSH;
                w_ctrl.aluop   = c_ALUOP_ADD;
            end
            c_MEMADR: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = c_SRCB_IMM;
                w_ctrl.aluop   = c_ALUOP_ADD;
            end
            c_MEMRD: begin
                w_ctrl.iord = 1'b1;
            end
            c_MEMWR: begin
                w_ctrl.iord     = 1'b1;
                w_ctrl.memwrite = 1'b1;
            end
            c_MEMWB: begin
                w_ctrl.memtoreg = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            c_EXECUTE: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = c_SRCB_B;
                w_ctrl.aluop   = c_ALUOP_FUNCT;
            end
            c_ALUWB: begin
                w_ctrl.regdst   = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            c_BRANCH: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = c_SRCB_B;
                w_ctrl.aluop   = c_ALUOP_SUB;
                w_ctrl.pcsrc   = c_PCSRC_ALUOUT;
                w_ctrl.branch  = 1'b1;
            end
            c_ADDIEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = c_SRCB_IMM;
                w_ctrl.aluop   = c_ALUOP_ADD;
            end
            c_SUBIEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = c_SRCB_IMM;
                w_ctrl.aluop   = c_ALUOP_SUB;
            end
            c_IMMWB: begin
                w_ctrl.regwrite = 1'b1;
            end
            c_JUMP: begin
                w_ctrl.pcsrc   = c_PCSRC_JUMP;
                w_ctrl.pcwrite = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign pcwrite  = w_ctrl.pcwrite;
    assign branch   = w_ctrl.branch;
    assign irwrite  = w_ctrl.irwrite;
    assign iord     = w_ctrl.iord;
    assign memwrite = w_ctrl.memwrite;
    assign regwrite = w_ctrl.regwrite;
    assign regdst   = w_ctrl.regdst;
    assign memtoreg = w_ctrl.memtoreg;
    assign alusrca  = w_ctrl.alusrca;
    assign alusrcb  = w_ctrl.alusrcb;
    assign aluop    = w_ctrl.aluop;
    assign pcsrc    = w_ctrl.pcsrc;

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle MIPS control FSM: sequencing, PC enable, illegal flag.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] r_state;
    logic [3:0] w_state_nxt;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_mem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_FETCH:   if (mem_ready) w_state_nxt = c_DECODE;
            c_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: w_state_nxt = c_MEMADR;
                    c_OP_RTYPE:       w_state_nxt = c_EXECUTE;
                    c_OP_BEQ:         w_state_nxt = c_BRANCH;
                    c_OP_ADDI:        w_state_nxt = c_ADDIEX;
                    c_OP_SUBI:        w_state_nxt = c_SUBIEX;
                    c_OP_J:           w_state_nxt = c_JUMP;
                    default:          w_state_nxt = c_FETCH;
                endcase
            end
            c_MEMADR:  w_state_nxt = (op == c_OP_LW) ? c_MEMRD : c_MEMWR;
            c_MEMRD:   if (mem_ready) w_state_nxt = c_MEMWB;
            c_MEMWR:   if (mem_ready) w_state_nxt = c_FETCH;
            c_EXECUTE: w_state_nxt = c_ALUWB;
            c_ADDIEX,
            c_SUBIEX:  w_state_nxt = c_IMMWB;
            c_MEMWB,
            c_ALUWB,
            c_BRANCH,
            c_IMMWB,
            c_JUMP:    w_state_nxt = c_FETCH;
            default:   w_state_nxt = c_FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH; masking the handshake keeps IR/PC quiet there.
    assign w_mem_ready = mem_ready & reset_n;

    ctrl_outdec u_outdec (
        .state     (r_state),
        .mem_ready (w_mem_ready),
        .pcwrite   (w_pcwrite),
        .branch    (w_branch),
        .irwrite   (irwrite),
        .iord      (iord),
        .memwrite  (memwrite),
        .regwrite  (regwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .pcsrc     (pcsrc)
    );

    assign pcen    = w_pcwrite | (w_branch & zero);
    assign illegal = (r_state == c_DECODE) && !is_supported_op(op);
    assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Directed self-checking bench for multicycle_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [5:0] op = 6'b000000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca, illegal;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pcen      (pcen),
        .irwrite   (irwrite),
        .iord      (iord),
        .memwrite  (memwrite),
        .regwrite  (regwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .pcsrc     (pcsrc),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    // {pcen,irwrite,iord,memwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,aluop,pcsrc,illegal}
    wire [14:0] w_obs = {pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
                         alusrca, alusrcb, aluop, pcsrc, illegal};

    function automatic logic [14:0] cv(input logic pe, input logic irw, input logic io,
                                       input logic mw, input logic rw, input logic rd,
                                       input logic m2r, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] ao, input logic [1:0] ps,
                                       input logic il);
        cv = {pe, irw, io, mw, rw, rd, m2r, sa, sb, ao, ps, il};
    endfunction

    task automatic chk(input string tag, input logic [3:0] exp_st, input logic [14:0] exp_cv);
        checks++;
        assert (state === exp_st) else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state, exp_st);
        end
        checks++;
        assert (w_obs === exp_cv) else begin
            errors++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, w_obs, exp_cv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [14:0] v_rst, v_f, v_d, v_dill, v_ma, v_mr, v_mw, v_mwb;
    logic [14:0] v_ex, v_awb, v_br1, v_br0, v_addi, v_subi, v_iwb, v_j;

    initial begin
        v_rst  = cv(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        v_f    = cv(1,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        v_d    = cv(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
        v_dill = cv(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
        v_ma   = cv(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        v_mr   = cv(0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        v_mw   = cv(0,0,1,1,0,0,0,0,2'b00,2'b00,2'b00,0);
        v_mwb  = cv(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
        v_ex   = cv(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
        v_awb  = cv(0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0);
        v_br1  = cv(1,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        v_br0  = cv(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        v_addi = cv(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        v_subi = cv(0,0,0,0,0,0,0,1,2'b10,2'b01,2'b00,0);
        v_iwb  = cv(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0);
        v_j    = cv(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);

        // Asynchronous reset before any clock edge; mem_ready=1 must not leak to irwrite/pcen
        #1 reset_n = 1'b0;
        #1 chk("reset_async", c_FETCH, v_rst);
        tick();
        chk("reset_held", c_FETCH, v_rst);

        // LW, no stalls: F D MA MR MWB
        @(negedge clk);
        reset_n = 1'b1; op = c_OP_LW; mem_ready = 1'b1;
        #1 chk("lw_fetch", c_FETCH, v_f);
        tick(); chk("lw_decode", c_DECODE, v_d);
        tick(); chk("lw_memadr", c_MEMADR, v_ma);
        tick(); chk("lw_memrd", c_MEMRD, v_mr);
        tick(); chk("lw_memwb", c_MEMWB, v_mwb);
        tick();

        // SW with one FETCH stall and three MEMWR stalls
        op = c_OP_SW; mem_ready = 1'b0;
        #1 chk("sw_fetch_stall", c_FETCH, v_rst);
        tick(); mem_ready = 1'b1;
        #1 chk("sw_fetch", c_FETCH, v_f);
        tick(); chk("sw_decode", c_DECODE, v_d);
        tick(); chk("sw_memadr", c_MEMADR, v_ma);
        tick(); mem_ready = 1'b0;
        #1 chk("sw_memwr_stall1", c_MEMWR, v_mw);
        tick(); chk("sw_memwr_stall2", c_MEMWR, v_mw);
        tick(); chk("sw_memwr_stall3", c_MEMWR, v_mw);
        tick(); mem_ready = 1'b1;
        #1 chk("sw_memwr_done", c_MEMWR, v_mw);
        tick();

        // LW with one MEMRD stall
        op = c_OP_LW;
        #1 chk("lw2_fetch", c_FETCH, v_f);
        tick(); tick(); tick(); mem_ready = 1'b0;
        #1 chk("lw2_memrd_stall", c_MEMRD, v_mr);
        tick(); mem_ready = 1'b1;
        #1 chk("lw2_memrd", c_MEMRD, v_mr);
        tick(); chk("lw2_memwb", c_MEMWB, v_mwb);
        tick();

        // R-type
        op = c_OP_RTYPE;
        #1 chk("r_fetch", c_FETCH, v_f);
        tick(); chk("r_decode", c_DECODE, v_d);
        tick(); chk("r_execute", c_EXECUTE, v_ex);
        tick(); chk("r_aluwb", c_ALUWB, v_awb);
        tick();

        // ADDI
        op = c_OP_ADDI;
        #1 chk("addi_fetch", c_FETCH, v_f);
        tick(); tick(); chk("addi_ex", c_ADDIEX, v_addi);
        tick(); chk("addi_wb", c_IMMWB, v_iwb);
        tick();

        // SUBI
        op = c_OP_SUBI;
        #1 chk("subi_fetch", c_FETCH, v_f);
        tick(); chk("subi_decode", c_DECODE, v_d);
        tick(); chk("subi_ex", c_SUBIEX, v_subi);
        tick(); chk("subi_wb", c_IMMWB, v_iwb);
        tick();

        // BEQ taken
        op = c_OP_BEQ; zero = 1'b1;
        #1 chk("beq1_fetch", c_FETCH, v_f);
        tick(); chk("beq1_decode", c_DECODE, v_d);
        tick(); chk("beq1_branch", c_BRANCH, v_br1);
        tick();

        // BEQ not taken
        zero = 1'b0;
        #1 chk("beq0_fetch", c_FETCH, v_f);
        tick(); tick(); chk("beq0_branch", c_BRANCH, v_br0);
        tick();

        // J
        op = c_OP_J;
        #1 chk("j_fetch", c_FETCH, v_f);
        tick(); chk("j_decode", c_DECODE, v_d);
        tick(); chk("j_jump", c_JUMP, v_j);
        tick();

        // nop: 2 cycles, no illegal
        op = c_OP_NOP;
        #1 chk("nop_fetch", c_FETCH, v_f);
        tick(); chk("nop_decode", c_DECODE, v_d);
        tick();

        // Unsupported opcode
        op = 6'b111111;
        #1 chk("ill_fetch", c_FETCH, v_f);
        tick(); chk("ill_decode", c_DECODE, v_dill);
        tick(); chk("ill_after", c_FETCH, v_f);

        // Reset during a stalled MEMWR
        op = c_OP_SW;
        tick(); tick(); tick(); mem_ready = 1'b0;
        #1 chk("rstw_memwr", c_MEMWR, v_mw);
        #2 reset_n = 1'b0; mem_ready = 1'b1;
        #1 chk("rstw_async", c_FETCH, v_rst);
        tick(); chk("rstw_held", c_FETCH, v_rst);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rstw_fetch", c_FETCH, v_f);
        tick(); chk("rstw_decode", c_DECODE, v_d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
